bresenham_stream: RTL and testbench

- Parametrised, all-octant Bresenham ray rasteriser for the occupancy-grid update path.
- Accepts one ray per handshake: sensor cell (x0,y0), beam endpoint cell (x1,y1) and a hit flag.
- Emits every traversed grid cell, one per cycle, as a valid/ready stream to the occupancy writer. Cells before the endpoint are marked free; the endpoint is marked occupied only on a hit.
- Out-of-grid cells are clipped, and downstream backpressure is honoured.

---
 rtl/bresenham_stream.sv | 110 +++++++++++
 tb/tb_bresenham_stream.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bresenham_stream.sv
// bresenham_stream: all-octant Bresenham ray rasteriser emitting clipped grid cells as a valid/ready stream
module bresenham_stream #(
    parameter int GRID_W     = 32,
    parameter int GRID_H     = 16,
    parameter int X_BITS     = 5,
    parameter int Y_BITS     = 4,
    parameter int COORD_BITS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ray_valid,
    output logic                  o_ray_ready,
    input  logic [COORD_BITS-1:0] i_x0,
    input  logic [COORD_BITS-1:0] i_y0,
    input  logic [COORD_BITS-1:0] i_x1,
    input  logic [COORD_BITS-1:0] i_y1,
    input  logic                  i_endpoint_hit,
    output logic                  o_cell_valid,
    input  logic                  i_cell_ready,
    output logic [X_BITS-1:0]     o_x_index,
    output logic [Y_BITS-1:0]     o_y_index,
    output logic                  o_cell_is_free,
    output logic                  o_cell_last,
    output logic                  o_busy,
    output logic                  o_ray_done
);
    localparam int W = COORD_BITS + 2;

    typedef enum logic [1:0] {IDLE, SETUP, EMIT} state_t;

    state_t              r_state, w_next;
    logic signed [W-1:0] r_x, r_y, r_x1, r_y1, r_dx, r_dy, r_err;
    logic                r_sx, r_sy, r_hit, r_done;
    logic signed [W-1:0] w_ddx, w_ddy, w_adx, w_ady, w_err, w_stx, w_sty;
    logic signed [W:0]   w_e2;
    logic                w_inb, w_end, w_step, w_mx, w_my;

    assign w_ddx  = r_x1 - r_x;
    assign w_ddy  = r_y1 - r_y;
    assign w_adx  = w_ddx[W-1] ? -w_ddx : w_ddx;
    assign w_ady  = w_ddy[W-1] ? -w_ddy : w_ddy;
    assign w_inb  = !r_x[W-1] && !r_y[W-1] && ($unsigned(r_x) < W'(GRID_W)) && ($unsigned(r_y) < W'(GRID_H));
    assign w_end  = (r_x == r_x1) && (r_y == r_y1);
    assign w_step = (r_state == EMIT) && (!w_inb || i_cell_ready);
    // e2 carries one extra bit so doubling err can never wrap
    assign w_e2   = $signed({r_err, 1'b0});
    assign w_mx   = w_e2 >= $signed({r_dy[W-1], r_dy});
    assign w_my   = w_e2 <= $signed({r_dx[W-1], r_dx});
    assign w_err  = r_err + (w_mx ? r_dy : '0) + (w_my ? r_dx : '0);
    assign w_stx  = r_sx ? '1 : W'(1);
    assign w_sty  = r_sy ? '1 : W'(1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_ray_valid) w_next = SETUP;
            SETUP:   w_next = EMIT;
            EMIT:    if (w_step && w_end) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_err   <= '0;
            r_sx    <= 1'b0;
            r_sy    <= 1'b0;
            r_hit   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_step && w_end;
            if (r_state == IDLE && i_ray_valid) begin
                r_x   <= {{2{i_x0[COORD_BITS-1]}}, i_x0};
                r_y   <= {{2{i_y0[COORD_BITS-1]}}, i_y0};
                r_x1  <= {{2{i_x1[COORD_BITS-1]}}, i_x1};
                r_y1  <= {{2{i_y1[COORD_BITS-1]}}, i_y1};
                r_hit <= i_endpoint_hit;
            end
            if (r_state == SETUP) begin
                r_dx  <= w_adx;
                r_dy  <= -w_ady;
                r_sx  <= w_ddx[W-1];
                r_sy  <= w_ddy[W-1];
                r_err <= w_adx - w_ady;
            end
            if (w_step && !w_end) begin
                r_err <= w_err;
                if (w_mx) r_x <= r_x + w_stx;
                if (w_my) r_y <= r_y + w_sty;
            end
        end
    end

    assign o_ray_ready    = r_state == IDLE;
    assign o_busy         = r_state != IDLE;
    assign o_cell_valid   = (r_state == EMIT) && w_inb;
    assign o_x_index      = r_x[X_BITS-1:0];
    assign o_y_index      = r_y[Y_BITS-1:0];
    assign o_cell_last    = o_cell_valid && w_end;
    assign o_cell_is_free = (r_state == EMIT) && !(w_end && r_hit);
    assign o_ray_done     = r_done;
endmodule

// File: tb/tb_bresenham_stream.sv
// tb_bresenham_stream: table-driven rays with a cell scoreboard, plus backpressure and mid-ray reset sequences
module tb_bresenham_stream;
    logic       clk = 0, rst_n = 0, ray_valid = 0, cell_ready = 1, hit = 0;
    logic [7:0] x0 = 0, y0 = 0, x1 = 0, y1 = 0;
    logic       ray_ready, cell_valid, cell_is_free, cell_last, busy, ray_done;
    logic [4:0] x_index;
    logic [3:0] y_index;

    bresenham_stream dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ray_valid(ray_valid), .o_ray_ready(ray_ready),
        .i_x0(x0), .i_y0(y0), .i_x1(x1), .i_y1(y1), .i_endpoint_hit(hit),
        .o_cell_valid(cell_valid), .i_cell_ready(cell_ready), .o_x_index(x_index), .o_y_index(y_index),
        .o_cell_is_free(cell_is_free), .o_cell_last(cell_last), .o_busy(busy), .o_ray_done(ray_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [4:0] x; logic [3:0] y; logic free; logic last;} cell_t;
    typedef struct {int x0, y0, x1, y1; bit hit; int emit, span, last;} vec_t;

    cell_t sbq[$];
    cell_t held;
    logic  hold = 0;
    int    errors = 0, checks = 0, cyc = 0, acc_cyc = 0, first_cyc = -1;
    int    n_acc = 0, n_last = 0, n_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_model(input int ax0, ay0, ax1, ay1, input bit ahit);
        int dx, dy, sx, sy, err, e2, x, y;
        cell_t c;
        dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
        sx = (ax1 < ax0) ? -1 : 1;
        sy = (ay1 < ay0) ? -1 : 1;
        err = dx + dy;
        x = ax0;
        y = ay0;
        for (int k = 0; k < 1000; k++) begin
            if (x >= 0 && x < 32 && y >= 0 && y < 16) begin
                c.x = x[4:0];
                c.y = y[3:0];
                c.last = (x == ax1 && y == ay1);
                c.free = !(c.last && ahit);
                sbq.push_back(c);
            end
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cell_t cur;
        cur = {x_index, y_index, cell_is_free, cell_last};
        if (!rst_n) hold = 0;
        else begin
            if (hold) begin
                chk("held_valid", cell_valid, 1);
                chk("held_cell", cur, held);
            end
            if (cell_valid && first_cyc < 0) first_cyc = cyc;
            if (cell_valid && cell_ready) begin
                n_acc++;
                n_last += cell_last;
                chk("sb_nonempty", sbq.size() > 0, 1);
                if (sbq.size() > 0) chk("cell", cur, sbq.pop_front());
            end
            if (cell_valid && !cell_ready) begin
                n_stall++;
                hold = 1;
                held = cur;
            end else hold = 0;
        end
    end

    task automatic send_ray(input int ax0, ay0, ax1, ay1, input bit ahit, output int lat);
        @(posedge clk);
        #1;
        x0 = ax0[7:0];
        y0 = ay0[7:0];
        x1 = ax1[7:0];
        y1 = ay1[7:0];
        hit = ahit;
        ray_valid = 1;
        n_acc = 0;
        n_last = 0;
        first_cyc = -1;
        push_model(ax0, ay0, ax1, ay1, ahit);
        @(negedge clk);
        chk("ray_ready", ray_ready, 1);
        acc_cyc = cyc;
        @(posedge clk);
        #1 ray_valid = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ray_done && lat < 1000);
        chk("ray_done_seen", ray_done, 1);
        @(negedge clk);
        chk("ray_done_pulse", ray_done, 0);
        chk("idle_busy", busy, 0);
        chk("sb_drained", sbq.size(), 0);
        sbq.delete();
    endtask

    vec_t vec[12];

    initial begin
        int lat, t;
        vec[0]  = '{0, 0, 4, 0, 1, 5, 5, 1};
        vec[1]  = '{3, 10, 5, 2, 0, 9, 9, 1};
        vec[2]  = '{7, 7, 7, 7, 1, 1, 1, 1};
        vec[3]  = '{30, 8, 35, 8, 1, 2, 6, 0};
        vec[4]  = '{-3, -3, 3, 3, 0, 4, 7, 1};
        vec[5]  = '{10, 5, 0, 0, 1, 11, 11, 1};
        vec[6]  = '{31, 15, 31, 0, 1, 16, 16, 1};
        vec[7]  = '{-5, 4, -1, 4, 1, 0, 5, 0};
        vec[8]  = '{20, 20, 25, 10, 0, 6, 11, 1};
        vec[9]  = '{-128, -128, 127, 127, 0, 16, 256, 0};
        vec[10] = '{127, -128, -128, 127, 1, 0, 256, 0};
        vec[11] = '{0, 15, 31, 0, 1, 32, 32, 1};

        repeat (2) @(negedge clk);
        chk("rst_ray_ready", ray_ready, 1);
        chk("rst_cell_valid", cell_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ray_done", ray_done, 0);
        chk("rst_x_index", x_index, 0);
        chk("rst_y_index", y_index, 0);
        chk("rst_cell_is_free", cell_is_free, 0);
        chk("rst_cell_last", cell_last, 0);
        @(posedge clk);
        #1 rst_n = 1;

        foreach (vec[i]) begin
            send_ray(vec[i].x0, vec[i].y0, vec[i].x1, vec[i].y1, vec[i].hit, lat);
            chk($sformatf("v%0d_emitted", i), n_acc, vec[i].emit);
            chk($sformatf("v%0d_lasts", i), n_last, vec[i].last);
            chk($sformatf("v%0d_latency", i), lat, vec[i].span + 2);
            if (vec[i].x0 >= 0 && vec[i].x0 < 32 && vec[i].y0 >= 0 && vec[i].y0 < 16)
                chk($sformatf("v%0d_first_cell", i), first_cyc - acc_cyc, 2);
        end

        n_stall = 0;
        fork
            send_ray(0, 0, 4, 0, 1, lat);
            begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!(cell_valid && x_index == 1) && t < 50);
                @(posedge clk);
                #1 cell_ready = 0;
                repeat (3) @(posedge clk);
                #1 cell_ready = 1;
            end
        join
        chk("bp_emitted", n_acc, 5);
        chk("bp_stalls", n_stall, 3);
        chk("bp_latency", lat, 10);

        @(posedge clk);
        #1;
        x0 = 0; y0 = 0; x1 = 9; y1 = 9; hit = 0;
        ray_valid = 1;
        n_acc = 0;
        push_model(0, 0, 9, 9, 0);
        @(posedge clk);
        #1 ray_valid = 0;
        t = 0;
        while (n_acc < 2 && t < 50) begin
            @(posedge clk);
            t++;
        end
        chk("mid_accepted", n_acc, 2);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_valid", cell_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ray_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_quiet", cell_valid, 0);
        end
        sbq.delete();
        @(posedge clk);
        #1 rst_n = 1;
        send_ray(5, 3, 8, 4, 1, lat);
        chk("post_rst_emitted", n_acc, 4);
        chk("post_rst_latency", lat, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
